// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: per-requester valid/ready
// handshake, packed address/data lanes and the read-return path.
interface ram_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AWID = 8,
    parameter int DWID = 16
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_we;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ*AWID-1:0] req_addr;
    logic [NREQ*DWID-1:0] req_din;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rvalid;
    logic [DWID-1:0]      rdata;

    // Client engines drive requests and observe grants / read returns.
    modport master (
        output req, req_we, req_lock, req_addr, req_din,
        input  gnt, rvalid, rdata
    );

    // The arbiter consumes requests and produces grants / read returns.
    modport slave (
        input  req, req_we, req_lock, req_addr, req_din,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between NREQ requesters: round-robin arbitration with
// optional burst lock, registered RAM command outputs and a 2-cycle read
// return pulse routed back to the requester that issued the read.
module ram_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AWID = 8,
    parameter int DWID = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_port_arbiter_if.slave bus,
    output logic            ram_we,
    output logic [AWID-1:0] ram_addr,
    output logic [DWID-1:0] ram_din,
    input  logic [DWID-1:0] ram_dout
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr, rr_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   winner, cand, sel;
    logic            found;
    logic            xfer;
    logic [NREQ-1:0] gnt_c;
    logic [NREQ-1:0] rd_pipe;
    logic [NREQ-1:0] rvalid_q;

    // Round-robin search: first active request at or above rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(rr_ptr) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Grant generation and next-state logic for the arbitration FSM.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        gnt_c     = '0;
        sel       = winner;
        case (state)
            ARB: begin
                if (found) begin
                    gnt_c[winner] = 1'b1;
                    rr_nxt = (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
                    if (bus.req_lock[winner]) begin
                        owner_nxt = winner;
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                sel          = owner;
                gnt_c[owner] = bus.req[owner];
                if (bus.req[owner] && !bus.req_lock[owner]) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
        // Grants are suppressed combinationally while reset is held.
        if (!rst_n) begin
            gnt_c = '0;
        end
    end

    assign bus.gnt    = gnt_c;
    assign xfer       = |(bus.req & gnt_c);
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = ram_dout;

    // FSM state, round-robin pointer and lock owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
            owner  <= owner_nxt;
        end
    end

    // Register the granted requester's command onto the RAM port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else if (xfer) begin
            ram_we   <= bus.req_we[sel];
            ram_addr <= bus.req_addr[32'(sel)*AWID +: AWID];
            ram_din  <= bus.req_din[32'(sel)*DWID +: DWID];
        end else begin
            ram_we   <= 1'b0;
        end
    end

    // Two-stage one-hot tag pipeline aligning rvalid with RAM read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe  <= '0;
            rvalid_q <= '0;
        end else begin
            rd_pipe  <= (xfer && !bus.req_we[sel]) ? gnt_c : '0;
            rvalid_q <= rd_pipe;
        end
    end
endmodule
